datamover_tcdm_responder: RTL and testbench

- TCDM slave (responder) that answers the requests issued by the datamover streamer's TCDM master port.
- Backed by a word-addressed register-array memory with a fixed, pipelined response latency.
- Grant stalls are injectable, so the streamer, its FIFO and its r_valid filter can be exercised under backpressure.
- Emits an r_valid strobe for writes as well as reads, matching real TCDM banks; the master side is responsible for filtering it.

---
 rtl/datamover_tcdm_responder.sv | 111 +++++++++++
 tb/tb_datamover_tcdm_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/datamover_tcdm_responder.sv
// TCDM responder for the datamover streamer: word-addressed register-array memory with a
// fixed-latency response pipeline and injectable grant stalls.
module datamover_tcdm_responder #(
   parameter int unsigned BW         = 32,
   parameter int unsigned NB_WORDS   = 1024,
   parameter int unsigned RD_LATENCY = 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              enable_i,
   input  logic              clear_i,
   input  logic              stall_i,
   input  logic              tcdm_req_i,
   output logic              tcdm_gnt_o,
   input  logic [31:0]       tcdm_add_i,
   input  logic              tcdm_wen_i,
   input  logic [BW/8-1:0]   tcdm_be_i,
   input  logic [BW-1:0]     tcdm_data_i,
   output logic [BW-1:0]     tcdm_r_data_o,
   output logic              tcdm_r_valid_o,
   output logic [31:0]       nb_reads_o,
   output logic [31:0]       nb_writes_o
);

   localparam int unsigned NbBytes = BW / 8;
   localparam int unsigned OffW    = $clog2(NbBytes);
   localparam int unsigned IdxW    = $clog2(NB_WORDS);

   logic                     w_gnt;
   logic                     w_accept;
   logic                     w_rd_accept;
   logic [IdxW-1:0]          w_idx;
   logic [BW-1:0]            w_rdata;
   logic                     w_unused_add;

   logic [BW-1:0]                  r_mem [NB_WORDS];
   logic [RD_LATENCY-1:0]          r_pipe_valid;
   logic [RD_LATENCY-1:0]          r_pipe_rd;
   logic [RD_LATENCY-1:0][BW-1:0]  r_pipe_data;
   logic [31:0]                    r_nb_reads;
   logic [31:0]                    r_nb_writes;

   // Clear wins over a simultaneous request, so nothing is accepted in a clear cycle.
   assign w_gnt       = tcdm_req_i & enable_i & ~stall_i & ~clear_i;
   assign w_accept    = tcdm_req_i & w_gnt;
   assign w_rd_accept = w_accept & tcdm_wen_i;

   // Byte offset and upper address bits are dropped, so addresses wrap over the memory size.
   assign w_idx        = tcdm_add_i[OffW +: IdxW];
   assign w_unused_add = ^{tcdm_add_i[31:OffW+IdxW], tcdm_add_i[OffW-1:0]};
   assign w_rdata      = r_mem[w_idx];

   // Byte-masked memory write; contents intentionally survive reset and clear.
   always_ff @(posedge clk_i) begin
      if (w_accept && !tcdm_wen_i) begin
         for (int i = 0; i < NbBytes; i++) begin
            if (tcdm_be_i[i]) begin
               r_mem[w_idx][8*i +: 8] <= tcdm_data_i[8*i +: 8];
            end
         end
      end
   end

   // Response shift register; stage 0 samples the addressed word at the accepting edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_pipe_valid <= '0;
         r_pipe_rd    <= '0;
         r_pipe_data  <= '0;
      end else if (clear_i) begin
         r_pipe_valid <= '0;
         r_pipe_rd    <= '0;
         r_pipe_data  <= '0;
      end else begin
         r_pipe_valid[0] <= w_accept;
         r_pipe_rd[0]    <= w_rd_accept;
         r_pipe_data[0]  <= w_rd_accept ? w_rdata : '0;
         for (int i = 1; i < RD_LATENCY; i++) begin
            r_pipe_valid[i] <= r_pipe_valid[i-1];
            r_pipe_rd[i]    <= r_pipe_rd[i-1];
            r_pipe_data[i]  <= r_pipe_data[i-1];
         end
      end
   end

   // Granted-transaction counters, wrapping naturally at 2^32.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_nb_reads  <= '0;
         r_nb_writes <= '0;
      end else if (clear_i) begin
         r_nb_reads  <= '0;
         r_nb_writes <= '0;
      end else if (w_accept) begin
         if (tcdm_wen_i) begin
            r_nb_reads <= r_nb_reads + 32'd1;
         end else begin
            r_nb_writes <= r_nb_writes + 32'd1;
         end
      end
   end

   assign tcdm_gnt_o     = w_gnt;
   assign tcdm_r_valid_o = r_pipe_valid[RD_LATENCY-1];
   // Write responses and idle cycles both present zero data.
   assign tcdm_r_data_o  = (r_pipe_valid[RD_LATENCY-1] && r_pipe_rd[RD_LATENCY-1]) ?
                           r_pipe_data[RD_LATENCY-1] : '0;
   assign nb_reads_o     = r_nb_reads;
   assign nb_writes_o    = r_nb_writes;

endmodule

// File: tb/tb_datamover_tcdm_responder.sv
// Self-checking bench: two responders (latency 1 and 3) share one stimulus stream and are
// compared every cycle against a queue-based transaction model.
module tb_datamover_tcdm_responder;

   logic        clk;
   logic        rst_n;
   logic        en, clr, stall, req, wen;
   logic [31:0] add, wdata;
   logic [3:0]  be;
   logic        gnt1, gnt3, rv1, rv3;
   logic [31:0] rd1, rd3, nr1, nr3, nw1, nw3;

   datamover_tcdm_responder #(.BW(32), .NB_WORDS(1024), .RD_LATENCY(1)) u_dut_l1 (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .clear_i(clr), .stall_i(stall),
      .tcdm_req_i(req), .tcdm_gnt_o(gnt1), .tcdm_add_i(add), .tcdm_wen_i(wen),
      .tcdm_be_i(be), .tcdm_data_i(wdata), .tcdm_r_data_o(rd1), .tcdm_r_valid_o(rv1),
      .nb_reads_o(nr1), .nb_writes_o(nw1)
   );

   datamover_tcdm_responder #(.BW(32), .NB_WORDS(1024), .RD_LATENCY(3)) u_dut_l3 (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .clear_i(clr), .stall_i(stall),
      .tcdm_req_i(req), .tcdm_gnt_o(gnt3), .tcdm_add_i(add), .tcdm_wen_i(wen),
      .tcdm_be_i(be), .tcdm_data_i(wdata), .tcdm_r_data_o(rd3), .tcdm_r_valid_o(rv3),
      .nb_reads_o(nr3), .nb_writes_o(nw3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          due;
      bit          rd;
      logic [31:0] data;
   } resp_t;

   resp_t       q1[$];
   resp_t       q3[$];
   logic [31:0] mmem [1024];
   int          cyc = 0;
   int          n_vec = 0;
   int          n_mis = 0;
   logic [31:0] m_rd = 0, m_wr = 0;
   bit          last_acc = 0;
   logic [31:0] last1 = 0, last3 = 0;
   int          rv_seen3 = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // One clock cycle: compare at the falling edge, then advance the model across the rising edge.
   task automatic step();
      bit          e_gnt, e_v1, e_v3, acc;
      logic [31:0] e_d1, e_d3, idx;
      resp_t       r;
      @(negedge clk);
      if (!rst_n) begin
         q1.delete(); q3.delete(); m_rd = 0; m_wr = 0;
      end
      e_gnt = req & en & ~stall & ~clr;
      e_v1  = (q1.size() > 0) && (q1[0].due == cyc);
      e_v3  = (q3.size() > 0) && (q3[0].due == cyc);
      e_d1  = (e_v1 && q1[0].rd) ? q1[0].data : 32'h0;
      e_d3  = (e_v3 && q3[0].rd) ? q3[0].data : 32'h0;
      chk("gnt_l1", {31'h0, gnt1}, {31'h0, e_gnt});
      chk("gnt_l3", {31'h0, gnt3}, {31'h0, e_gnt});
      chk("rvalid_l1", {31'h0, rv1}, {31'h0, e_v1});
      chk("rvalid_l3", {31'h0, rv3}, {31'h0, e_v3});
      chk("rdata_l1", rd1, e_d1);
      chk("rdata_l3", rd3, e_d3);
      chk("nb_reads_l1", nr1, m_rd);
      chk("nb_reads_l3", nr3, m_rd);
      chk("nb_writes_l1", nw1, m_wr);
      chk("nb_writes_l3", nw3, m_wr);
      if (e_v1) begin
         if (q1[0].rd) last1 = rd1;
         void'(q1.pop_front());
      end
      if (e_v3) begin
         if (q3[0].rd) last3 = rd3;
         void'(q3.pop_front());
      end
      if (rv3) rv_seen3++;
      acc = e_gnt & rst_n;
      if (clr && rst_n) begin
         q1.delete(); q3.delete(); m_rd = 0; m_wr = 0;
      end else if (acc) begin
         idx = (add >> 2) % 1024;
         r.rd = wen;
         r.data = wen ? mmem[idx] : 32'h0;
         if (wen) begin
            m_rd++;
         end else begin
            m_wr++;
            for (int i = 0; i < 4; i++)
               if (be[i]) mmem[idx][8*i +: 8] = wdata[8*i +: 8];
         end
         r.due = cyc + 1; q1.push_back(r);
         r.due = cyc + 3; q3.push_back(r);
      end
      last_acc = acc;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic txn(input logic w, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d);
      int n = 0;
      req = 1'b1; wen = w; add = a; be = b; wdata = d;
      do begin
         step();
         n++;
      end while (!last_acc && n < 20);
      if (!last_acc) begin
         n_vec++; n_mis++;
         $display("FAIL txn_timeout: no grant after %0d cycles, add %h", n, a);
      end
   endtask

   task automatic idle(input int n);
      req = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      logic [31:0] up, ix, lo;
      rst_n = 1'b0; en = 1'b0; clr = 1'b0; stall = 1'b0; req = 1'b0;
      wen = 1'b0; add = 0; be = 0; wdata = 0;
      for (int i = 0; i < 1024; i++) mmem[i] = 32'h0;
      step(); step();
      chk("reset_rvalid", {31'h0, rv3}, 32'h0);
      chk("reset_rdata", rd3, 32'h0);
      chk("reset_gnt", {31'h0, gnt1}, 32'h0);
      rst_n = 1'b1; en = 1'b1;
      idle(1);

      // Preload word k with value k.
      for (int k = 0; k < 64; k++) txn(1'b0, k * 4, 4'hF, k);
      idle(4);

      // Write then read back.
      txn(1'b0, 32'h10, 4'hF, 32'hDEADBEEF);
      txn(1'b1, 32'h10, 4'h0, 32'h0);
      idle(4);
      chk("lit_wr_rd_l1", last1, 32'hDEADBEEF);
      chk("lit_wr_rd_l3", last3, 32'hDEADBEEF);

      // Byte enables.
      txn(1'b0, 32'h20, 4'hF, 32'h11223344);
      txn(1'b0, 32'h20, 4'h5, 32'hAABBCCDD);
      txn(1'b1, 32'h20, 4'h0, 32'h0);
      idle(4);
      chk("lit_be_l1", last1, 32'h11BB33DD);

      // Three stalled cycles, then one grant.
      stall = 1'b1; req = 1'b1; wen = 1'b1; add = 32'h4;
      step(); step(); step();
      stall = 1'b0;
      step();
      chk("lit_stall_acc", {31'h0, last_acc}, 32'h1);
      idle(4);
      chk("lit_stall_l3", last3, 32'h1);

      // Eight back-to-back reads.
      for (int k = 0; k < 8; k++) txn(1'b1, k * 4, 4'h0, 32'h0);
      idle(5);
      chk("lit_pipe_l3", last3, 32'h7);

      // Address wrap.
      txn(1'b0, 32'h1000, 4'hF, 32'hCAFE0001);
      txn(1'b1, 32'h0, 4'h0, 32'h0);
      idle(4);
      chk("lit_wrap_l3", last3, 32'hCAFE0001);

      // Clear one cycle after two read grants.
      txn(1'b1, 32'h14, 4'h0, 32'h0);
      txn(1'b1, 32'h18, 4'h0, 32'h0);
      req = 1'b0; clr = 1'b1;
      rv_seen3 = 0;
      step();
      clr = 1'b0;
      idle(5);
      chk("lit_clr_rv_l3", rv_seen3, 32'h0);
      chk("lit_clr_nrd_l3", nr3, 32'h0);

      // Reset pulse one cycle after two read grants.
      txn(1'b1, 32'h14, 4'h0, 32'h0);
      txn(1'b1, 32'h18, 4'h0, 32'h0);
      req = 1'b0; rst_n = 1'b0;
      rv_seen3 = 0;
      step();
      rst_n = 1'b1;
      idle(5);
      chk("lit_rst_rv_l3", rv_seen3, 32'h0);
      chk("lit_rst_nrd_l3", nr3, 32'h0);
      txn(1'b1, 32'h10, 4'h0, 32'h0);
      idle(4);
      chk("lit_rst_mem_l3", last3, 32'hDEADBEEF);

      // Random traffic; an ungranted request keeps its fields until granted.
      for (int c = 0; c < 2000; c++) begin
         en    = ($urandom_range(0, 9) != 0);
         stall = ($urandom_range(0, 3) == 0);
         clr   = ($urandom_range(0, 39) == 0);
         if (!(req && !last_acc)) begin
            req = ($urandom_range(0, 9) < 7);
            wen = $urandom_range(0, 1);
            up = $urandom; ix = $urandom_range(0, 63); lo = $urandom_range(0, 3);
            add = {up[19:0], ix[9:0], lo[1:0]};
            be = 4'($urandom);
            wdata = $urandom;
         end
         step();
      end
      en = 1'b1; stall = 1'b0; clr = 1'b0;
      idle(5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
